// File: rtl/imm_decode_stage.sv
// RV immediate decoder with a registered valid/ready output and a 2-entry skid buffer.
// Only the decoded result is stored, so IN_READY depends on local state only.
module imm_decode_stage #(
   parameter int XLEN      = 32,
   parameter bit AUTO_FMT  = 1'b1,
   parameter int ILL_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [31:0]          instruction_i,
   input  logic [2:0]           selection_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [XLEN-1:0]      imm_o,
   output logic [2:0]           fmt_o,
   output logic                 illegal_o,
   output logic [ILL_CNT_W-1:0] ill_count_o
);

   localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_U = 3'd2,
                          F_S = 3'd3, F_B = 3'd4, F_J = 3'd5;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            ill;
   } entry_t;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

   state_e              state_q, state_d;
   entry_t              or_q, sr_q, dec_e;
   logic [ILL_CNT_W-1:0] cnt_q;
   logic [2:0]          dec_fmt;
   logic                dec_ill;
   logic [31:0]         raw;
   logic [XLEN-1:0]     dec_imm;
   logic                accept, pop;
   logic                or_ld_new, or_ld_sr, or_clr, sr_ld;

   // Format resolution; illegal decodes collapse to format none so the immediate is zero.
   always_comb begin
      dec_fmt = F_NONE;
      dec_ill = 1'b0;
      if (AUTO_FMT) begin
         case (instruction_i[6:0])
            7'b0000011, 7'b0001111, 7'b0010011,
            7'b1100111, 7'b1110011:             dec_fmt = F_I;
            7'b0010111, 7'b0110111:             dec_fmt = F_U;
            7'b0100011:                         dec_fmt = F_S;
            7'b1100011:                         dec_fmt = F_B;
            7'b1101111:                         dec_fmt = F_J;
            7'b0110011:                         dec_fmt = F_NONE;
            7'b0011011: if (XLEN == 64) dec_fmt = F_I; else dec_ill = 1'b1;
            7'b0111011: if (XLEN != 64) dec_ill = 1'b1;
            default:                            dec_ill = 1'b1;
         endcase
      end else begin
         if (selection_i > F_J) dec_ill = 1'b1;
         else                   dec_fmt = selection_i;
      end
   end

   always_comb begin
      raw = '0;
      case (dec_fmt)
         F_I:     raw = {{20{instruction_i[31]}}, instruction_i[31:20]};
         F_U:     raw = {instruction_i[31:12], 12'b0};
         F_S:     raw = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
         F_B:     raw = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0};
         F_J:     raw = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0};
         default: raw = '0;
      endcase
   end

   if (XLEN == 64) begin : g_rv64
      assign dec_imm = {{32{raw[31]}}, raw};
   end else begin : g_rv32
      assign dec_imm = raw;
   end

   always_comb begin
      dec_e.imm = dec_imm;
      dec_e.fmt = dec_fmt;
      dec_e.ill = dec_ill;
   end

   assign in_ready_o  = (state_q != S_FULL);
   assign out_valid_o = (state_q != S_EMPTY);
   assign accept      = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      or_ld_new = 1'b0;
      or_ld_sr  = 1'b0;
      or_clr    = 1'b0;
      sr_ld     = 1'b0;
      case (state_q)
         S_EMPTY: if (accept) begin
            or_ld_new = 1'b1;
            state_d   = S_ONE;
         end
         S_ONE: begin
            if (accept && pop) begin
               or_ld_new = 1'b1;
            end else if (accept) begin
               sr_ld   = 1'b1;
               state_d = S_FULL;
            end else if (pop) begin
               or_clr  = 1'b1;
               state_d = S_EMPTY;
            end
         end
         S_FULL: if (pop) begin
            or_ld_sr = 1'b1;
            state_d  = S_ONE;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // OR is zeroed when drained so an empty stage never shows a stale result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         or_q  <= '0;
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (or_ld_new)     or_q <= dec_e;
         else if (or_ld_sr) or_q <= sr_q;
         else if (or_clr)   or_q <= '0;
         if (sr_ld) sr_q <= dec_e;
         if (accept && dec_ill && (cnt_q != '1)) cnt_q <= cnt_q + ILL_CNT_W'(1);
      end
   end

   assign imm_o       = or_q.imm;
   assign fmt_o       = or_q.fmt;
   assign illegal_o   = or_q.ill;
   assign ill_count_o = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench: three stage variants (RV32 auto, RV64 auto, RV32 manual with 2-bit counter)
// share one input stream and are each checked against a queue-based reference model.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] inst = '0;
   logic [2:0]  sel = '0;

   logic        rdy32, vld32, ill32, rdy64, vld64, ill64, rdym, vldm, illm;
   logic [31:0] imm32, immm;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64, fmtm;
   logic [15:0] cnt32, cnt64;
   logic [1:0]  cntm;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .AUTO_FMT(1'b1), .ILL_CNT_W(16)) u32 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
      .instruction_i(inst), .selection_i(sel), .out_valid_o(vld32), .out_ready_i(out_ready),
      .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32), .ill_count_o(cnt32));
   imm_decode_stage #(.XLEN(64), .AUTO_FMT(1'b1), .ILL_CNT_W(16)) u64 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
      .instruction_i(inst), .selection_i(sel), .out_valid_o(vld64), .out_ready_i(out_ready),
      .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64), .ill_count_o(cnt64));
   imm_decode_stage #(.XLEN(32), .AUTO_FMT(1'b0), .ILL_CNT_W(2)) um (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdym),
      .instruction_i(inst), .selection_i(sel), .out_valid_o(vldm), .out_ready_i(out_ready),
      .imm_o(immm), .fmt_o(fmtm), .illegal_o(illm), .ill_count_o(cntm));

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } ent_t;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  sel;
      logic [31:0] imm32;
      logic [2:0]  fmt32;
      logic        ill32;
      logic [63:0] imm64;
      logic [2:0]  fmt64;
      logic        ill64;
   } vec_t;

   ent_t q32[$], q64[$], qm[$];
   int   c32 = 0, c64 = 0, cm = 0;
   int   n_pass = 0, n_total = 0;
   logic [6:0] ops [0:15];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endfunction

   // Reference decode: field values are taken as signed numbers and widened arithmetically.
   function automatic ent_t ref_dec(input logic [31:0] w, input logic [2:0] s,
                                    input bit autof, input bit x64);
      ent_t   r;
      int     f = 0;
      bit     il = 0;
      longint v = 0;
      if (autof) begin
         case (w[6:0])
            7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: f = 1;
            7'b0010111, 7'b0110111: f = 2;
            7'b0100011: f = 3;
            7'b1100011: f = 4;
            7'b1101111: f = 5;
            7'b0110011: f = 0;
            7'b0011011: if (x64) f = 1; else il = 1;
            7'b0111011: il = !x64;
            default:    il = 1;
         endcase
      end else if (s > 3'd5) il = 1;
      else f = int'(s);
      case (f)
         1: v = $signed(w[31:20]);
         2: v = $signed({w[31:12], 12'b0});
         3: v = $signed({w[31:25], w[11:7]});
         4: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
         5: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
         default: v = 0;
      endcase
      if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
      r.imm = v;
      r.fmt = f[2:0];
      r.ill = il;
      return r;
   endfunction

   function automatic void model_reset();
      q32.delete(); q64.delete(); qm.delete();
      c32 = 0; c64 = 0; cm = 0;
   endfunction

   task automatic check_all();
      chk("rdy32", 64'(rdy32), 64'(q32.size() < 2));
      chk("rdy64", 64'(rdy64), 64'(q64.size() < 2));
      chk("rdym",  64'(rdym),  64'(qm.size() < 2));
      chk("vld32", 64'(vld32), 64'(q32.size() > 0));
      chk("vld64", 64'(vld64), 64'(q64.size() > 0));
      chk("vldm",  64'(vldm),  64'(qm.size() > 0));
      chk("cnt32", 64'(cnt32), 64'(c32));
      chk("cnt64", 64'(cnt64), 64'(c64));
      chk("cntm",  64'(cntm),  64'(cm));
      if (q32.size() > 0) begin
         chk("imm32", 64'(imm32), q32[0].imm);
         chk("fmt32", 64'(fmt32), 64'(q32[0].fmt));
         chk("ill32", 64'(ill32), 64'(q32[0].ill));
      end
      if (q64.size() > 0) begin
         chk("imm64", imm64, q64[0].imm);
         chk("fmt64", 64'(fmt64), 64'(q64[0].fmt));
         chk("ill64", 64'(ill64), 64'(q64[0].ill));
      end
      if (qm.size() > 0) begin
         chk("immm", 64'(immm), qm[0].imm);
         chk("fmtm", 64'(fmtm), 64'(qm[0].fmt));
         chk("illm", 64'(illm), 64'(qm[0].ill));
      end
   endtask

   // One clock: predict handshake from model occupancy, advance, then compare.
   task automatic step();
      bit   acc, pp;
      ent_t e;
      acc = in_valid && (q32.size() < 2);
      pp  = out_ready && (q32.size() > 0);
      @(posedge clk); #1;
      if (pp) begin
         void'(q32.pop_front()); void'(q64.pop_front()); void'(qm.pop_front());
      end
      if (acc) begin
         e = ref_dec(inst, sel, 1, 0); q32.push_back(e); if (e.ill && c32 < 65535) c32++;
         e = ref_dec(inst, sel, 1, 1); q64.push_back(e); if (e.ill && c64 < 65535) c64++;
         e = ref_dec(inst, sel, 0, 0); qm.push_back(e);  if (e.ill && cm < 3) cm++;
      end
      check_all();
   endtask

   vec_t        tbl [9];
   logic [31:0] got [$];
   logic [31:0] bp_exp [3];
   bit          c_taken;

   initial begin
      ops = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0010111,
              7'b0110111, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110011, 7'b0011011,
              7'b0111011, 7'b1111111, 7'b0000000, 7'b1010101};
      tbl[0] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
      tbl[1] = '{32'h12345037, 3'd2, 32'h12345000, 3'd2, 1'b0, 64'h0000000012345000, 3'd2, 1'b0};
      tbl[2] = '{32'hFE112E23, 3'd3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
      tbl[3] = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
      tbl[4] = '{32'hFE000EE3, 3'd4, 32'hFFFFFFFC, 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0};
      tbl[5] = '{32'h80000037, 3'd2, 32'h80000000, 3'd2, 1'b0, 64'hFFFFFFFF80000000, 3'd2, 1'b0};
      tbl[6] = '{32'h0010009B, 3'd1, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0};
      tbl[7] = '{32'h0000007F, 3'd6, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
      tbl[8] = '{32'h00B50533, 3'd0, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};

      // Reset values
      #3;
      chk("rst_vld", 64'(vld32), 64'd0);
      chk("rst_rdy", 64'(rdy32), 64'd1);
      chk("rst_imm", 64'(imm32), 64'd0);
      chk("rst_fmt", 64'(fmt32), 64'd0);
      chk("rst_ill", 64'(ill32), 64'd0);
      chk("rst_cnt", 64'(cnt32), 64'd0);
      @(negedge clk); rst = 1'b0;

      // Directed vectors, back-to-back with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; inst = tbl[i].inst; sel = tbl[i].sel;
         step();
         chk($sformatf("tbl%0d_rdy", i),   64'(rdy32), 64'd1);
         chk($sformatf("tbl%0d_vld", i),   64'(vld32), 64'd1);
         chk($sformatf("tbl%0d_imm32", i), 64'(imm32), 64'(tbl[i].imm32));
         chk($sformatf("tbl%0d_fmt32", i), 64'(fmt32), 64'(tbl[i].fmt32));
         chk($sformatf("tbl%0d_ill32", i), 64'(ill32), 64'(tbl[i].ill32));
         chk($sformatf("tbl%0d_imm64", i), imm64,      tbl[i].imm64);
         chk($sformatf("tbl%0d_fmt64", i), 64'(fmt64), 64'(tbl[i].fmt64));
         chk($sformatf("tbl%0d_ill64", i), 64'(ill64), 64'(tbl[i].ill64));
      end
      chk("sel6_illm", 64'(illm), 64'd0);  // row 8 uses sel=0 on the manual instance
      in_valid = 1'b0; step();

      // Back-pressure: three offers with consumer stalled
      bp_exp = '{32'h11111000, 32'h22222000, 32'h33333000};
      out_ready = 1'b0; in_valid = 1'b1; sel = 3'd2;
      inst = 32'h11111037; step();
      inst = 32'h22222037; step();
      chk("bp_rdy_full", 64'(rdy32), 64'd0);
      inst = 32'h33333037; step();
      chk("bp_rdy_hold", 64'(rdy32), 64'd0);
      chk("bp_hold_imm", 64'(imm32), 64'h11111000);
      out_ready = 1'b1; c_taken = 0;
      for (int k = 0; k < 10 && got.size() < 3; k++) begin
         if (vld32) got.push_back(imm32);
         if (rdy32 && in_valid) c_taken = 1;
         step();
         if (c_taken) in_valid = 1'b0;
      end
      chk("bp_count", 64'(got.size()), 64'd3);
      for (int k = 0; k < 3 && k < got.size(); k++)
         chk($sformatf("bp_order%0d", k), 64'(got[k]), 64'(bp_exp[k]));
      in_valid = 1'b0; step();

      // Async reset while FULL
      out_ready = 1'b0; in_valid = 1'b1; inst = 32'h0000007F; sel = 3'd7;
      step(); step();
      chk("full_rdy", 64'(rdy32), 64'd0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_vld", 64'(vld32), 64'd0);
      chk("arst_rdy", 64'(rdy32), 64'd1);
      chk("arst_cnt", 64'(cnt32), 64'd0);
      chk("arst_cntm", 64'(cntm), 64'd0);
      #2 rst = 1'b0;
      out_ready = 1'b1; inst = 32'hFFF00093; sel = 3'd1;
      step();
      chk("post_rst_vld", 64'(vld32), 64'd1);
      chk("post_rst_imm", 64'(imm32), 64'hFFFFFFFF);

      // Illegal counting and saturation of the 2-bit counter
      inst = 32'h0000007F; sel = 3'd7;
      step();
      chk("ill_cnt_1", 64'(cnt32), 64'd1);
      chk("ill_flag",  64'(ill32), 64'd1);
      chk("ill_imm",   64'(imm32), 64'd0);
      chk("sel7_illm", 64'(illm), 64'd1);
      sel = 3'd6;
      step();
      chk("sel6_illm2", 64'(illm), 64'd1);
      step(); step(); step();
      chk("cntm_sat", 64'(cntm), 64'd3);
      chk("cnt32_5",  64'(cnt32), 64'd5);
      in_valid = 1'b0; step();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         inst      = $urandom;
         if ($urandom_range(0, 9) < 8) inst[6:0] = ops[$urandom_range(0, 15)];
         sel       = 3'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
